// File: rtl/pc_branch_ctrl.sv
// Program-counter sequencer driving instruction fetch and branch-target LUT lookups.
// Latency: pc advances one step per edge; taken branch costs one bubble (BRANCH state).
// Backpressure: stall freezes pc/state/count in RUN only; BRANCH always completes in one cycle.
//
// Ports:
//   Clk, Reset_n       clock and synchronous active-low reset
//   start              begin program at START_PC (honoured in IDLE/HALT only)
//   stall              freeze PC/state for this cycle (RUN only)
//   halt_req           current instruction is halt
//   branch_taken       current instruction is a taken branch
//   branch_sel         LUT index carried by the branch instruction
//   lut_addr           registered LUT index
//   lut_branch         registered LUT lookup strobe (high only in BRANCH)
//   lut_target         absolute target from LUT, combinational in the same cycle
//   pc                 current fetch address
//   fetch_valid        pc holds a live instruction address (state == RUN)
//   done               program halted; held until the next start
//   instr_count        instructions retired since last start, saturating
module pc_branch_ctrl #(
  parameter int unsigned    D        = 10,
  parameter int unsigned    A        = 8,
  parameter logic [D-1:0]   START_PC = '0,
  parameter int unsigned    CW       = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          branch_taken,
  input  logic [A-1:0]  branch_sel,
  output logic [A-1:0]  lut_addr,
  output logic          lut_branch,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  pc,
  output logic          fetch_valid,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_BRANCH = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t        state_q,      state_d;
  logic [D-1:0]  pc_q,         pc_d;
  logic [A-1:0]  lut_addr_q,   lut_addr_d;
  logic          lut_branch_q, lut_branch_d;
  logic          done_q,       done_d;
  logic [CW-1:0] count_q,      count_d;

  logic [CW-1:0] count_inc;

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  assign count_inc = (count_q == {CW{1'b1}}) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    lut_addr_d   = lut_addr_q;
    lut_branch_d = lut_branch_q;
    done_d       = done_q;
    count_d      = count_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          count_d = '0;
          done_d  = 1'b0;
        end
      end

      S_RUN: begin
        if (stall) begin
          // Whole pipeline frozen; decode inputs are not acted on this cycle.
          state_d = S_RUN;
        end else if (halt_req) begin
          // Halt outranks a simultaneous branch and is not counted as retired.
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (branch_taken) begin
          state_d      = S_BRANCH;
          lut_addr_d   = branch_sel;
          lut_branch_d = 1'b1;
          count_d      = count_inc;
        end else begin
          pc_d    = pc_q + 1'b1;
          count_d = count_inc;
        end
      end

      S_BRANCH: begin
        // LUT answers combinationally while lut_branch is high; lut_addr is
        // left at its last value since only the strobe qualifies it.
        state_d      = S_RUN;
        pc_d         = lut_target;
        lut_branch_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      lut_addr_q   <= '0;
      lut_branch_q <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      lut_addr_q   <= lut_addr_d;
      lut_branch_q <= lut_branch_d;
      done_q       <= done_d;
      count_q      <= count_d;
    end
  end

  assign pc          = pc_q;
  assign lut_addr    = lut_addr_q;
  assign lut_branch  = lut_branch_q;
  assign done        = done_q;
  assign instr_count = count_q;
  assign fetch_valid = (state_q == S_RUN);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Testbench for pc_branch_ctrl: default-width instance plus a narrow instance
// (D=4, START_PC=14, CW=2) for wrap and saturation; both share the stimulus.
module tb_pc_branch_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic        stall;
  logic        halt_req;
  logic        branch_taken;
  logic [7:0]  branch_sel;

  logic [7:0]  lut_addr;
  logic        lut_branch;
  logic [9:0]  lut_target;
  logic [9:0]  pc;
  logic        fetch_valid;
  logic        done;
  logic [15:0] instr_count;

  logic [7:0]  lut_addr_s;
  logic        lut_branch_s;
  logic [3:0]  lut_target_s;
  logic [3:0]  pc_s;
  logic        fetch_valid_s;
  logic        done_s;
  logic [1:0]  instr_count_s;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic       rn;
    logic       st;
    logic       sl;
    logic       h;
    logic       b;
    logic [7:0] sel;
  } stim_t;

  typedef struct packed {
    logic [9:0]  pc;
    logic        fv;
    logic        lb;
    logic [7:0]  la;
    logic        dn;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic [3:0] pc;
    logic       fv;
    logic [1:0] cnt;
  } obs_s_t;

  obs_t   sb[$];
  obs_s_t sb_s[$];

  pc_branch_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .stall(stall),
    .halt_req(halt_req), .branch_taken(branch_taken), .branch_sel(branch_sel),
    .lut_addr(lut_addr), .lut_branch(lut_branch), .lut_target(lut_target),
    .pc(pc), .fetch_valid(fetch_valid), .done(done), .instr_count(instr_count)
  );

  pc_branch_ctrl #(.D(4), .A(8), .START_PC(4'd14), .CW(2)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .stall(stall),
    .halt_req(halt_req), .branch_taken(branch_taken), .branch_sel(branch_sel),
    .lut_addr(lut_addr_s), .lut_branch(lut_branch_s), .lut_target(lut_target_s),
    .pc(pc_s), .fetch_valid(fetch_valid_s), .done(done_s), .instr_count(instr_count_s)
  );

  // LUT model: index 1 -> 20, index 2 -> 0 (legal jump to 0), others -> 3*index.
  function automatic logic [9:0] lut_fn(input logic [7:0] a);
    case (a)
      8'd1:    return 10'd20;
      8'd2:    return 10'd0;
      default: return 10'(a) * 10'd3;
    endcase
  endfunction

  assign lut_target   = lut_branch   ? lut_fn(lut_addr) : 10'd0;
  assign lut_target_s = lut_branch_s ? lut_addr_s[3:0]  : 4'd0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic stim_t st(input logic rn, input logic s, input logic sl,
                               input logic h, input logic b, input logic [7:0] sel);
    return '{rn: rn, st: s, sl: sl, h: h, b: b, sel: sel};
  endfunction

  function automatic obs_t ob(input int p, input logic fv, input logic lb,
                              input int la, input logic dn, input int cnt);
    return '{pc: 10'(p), fv: fv, lb: lb, la: 8'(la), dn: dn, cnt: 16'(cnt)};
  endfunction

  function automatic obs_t cur_obs();
    return '{pc: pc, fv: fetch_valid, lb: lut_branch, la: lut_addr, dn: done, cnt: instr_count};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%0d fv=%0b lb=%0b la=%0d done=%0b cnt=%0d",
                     o.pc, o.fv, o.lb, o.la, o.dn, o.cnt);
  endfunction

  task automatic drive(input stim_t s);
    Reset_n      = s.rn;
    start        = s.st;
    stall        = s.sl;
    halt_req     = s.h;
    branch_taken = s.b;
    branch_sel   = s.sel;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reset dominates start; all outputs zero.
  task automatic test_reset();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, exp_o;
    s.push_back(st(0, 1, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      tick();
      exp_o = sb.pop_front();
      got   = cur_obs();
      vectors++;
      if (got !== exp_o) begin
        miscompares++;
        $display("FAIL reset[%0d] got %s want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  // Start pulse then five straight-line instructions.
  task automatic test_run();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, exp_o;
    s.push_back(st(0, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back(ob(0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(k, 1, 0, 0, 0, k));
    end
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      tick();
      exp_o = sb.pop_front();
      got   = cur_obs();
      vectors++;
      if (got !== exp_o) begin
        miscompares++;
        $display("FAIL run[%0d] got %s want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  // Branch at pc=3 to 20, stall ignored in BRANCH, then a jump to target 0.
  task automatic test_branch();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, exp_o;
    s.push_back(st(0, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back(ob(0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(k, 1, 0, 0, 0, k));
    end
    s.push_back(st(1, 0, 0, 0, 1, 8'd1)); e.push_back(ob(3, 0, 1, 1, 0, 4));
    s.push_back(st(1, 0, 1, 0, 0, 8'd0)); e.push_back(ob(20, 1, 0, 1, 0, 4));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(21, 1, 0, 1, 0, 5));
    s.push_back(st(1, 0, 0, 0, 1, 8'd2)); e.push_back(ob(21, 0, 1, 2, 0, 6));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 1, 0, 2, 0, 6));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(1, 1, 0, 2, 0, 7));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      tick();
      exp_o = sb.pop_front();
      got   = cur_obs();
      vectors++;
      if (got !== exp_o) begin
        miscompares++;
        $display("FAIL branch[%0d] got %s want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  // Halt and branch together at pc=7: halt wins, no lookup; restart from HALT.
  task automatic test_halt_priority();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, exp_o;
    s.push_back(st(0, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back(ob(0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) begin
      s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(k, 1, 0, 0, 0, k));
    end
    s.push_back(st(1, 0, 0, 1, 1, 8'd5)); e.push_back(ob(7, 0, 0, 0, 1, 7));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(7, 0, 0, 0, 1, 7));
    s.push_back(st(1, 0, 1, 1, 1, 8'd4)); e.push_back(ob(7, 0, 0, 0, 1, 7));
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back(ob(0, 1, 0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(1, 1, 0, 0, 0, 1));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      tick();
      exp_o = sb.pop_front();
      got   = cur_obs();
      vectors++;
      if (got !== exp_o) begin
        miscompares++;
        $display("FAIL halt[%0d] got %s want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  // Stall over a pending branch, then the branch proceeds; start in RUN ignored.
  task automatic test_stall();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, exp_o;
    s.push_back(st(0, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back(ob(0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(k, 1, 0, 0, 0, k));
    end
    for (int k = 0; k < 3; k++) begin
      s.push_back(st(1, 0, 1, 0, 1, 8'd3)); e.push_back(ob(4, 1, 0, 0, 0, 4));
    end
    s.push_back(st(1, 0, 0, 0, 1, 8'd3)); e.push_back(ob(4, 0, 1, 3, 0, 5));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(9, 1, 0, 3, 0, 5));
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back(ob(10, 1, 0, 3, 0, 6));
    s.push_back(st(1, 0, 1, 1, 0, 8'd0)); e.push_back(ob(10, 1, 0, 3, 0, 6));
    s.push_back(st(1, 0, 0, 1, 0, 8'd0)); e.push_back(ob(10, 0, 0, 3, 1, 6));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      tick();
      exp_o = sb.pop_front();
      got   = cur_obs();
      vectors++;
      if (got !== exp_o) begin
        miscompares++;
        $display("FAIL stall[%0d] got %s want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  // Narrow instance: pc wraps 15 -> 0, counter saturates at 3.
  task automatic test_wrap_saturate();
    stim_t  s[$];
    obs_s_t e[$];
    obs_s_t got, exp_o;
    s.push_back(st(0, 0, 0, 0, 0, 8'd0)); e.push_back('{pc: 4'd0,  fv: 1'b0, cnt: 2'd0});
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back('{pc: 4'd14, fv: 1'b1, cnt: 2'd0});
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back('{pc: 4'd15, fv: 1'b1, cnt: 2'd1});
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back('{pc: 4'd0,  fv: 1'b1, cnt: 2'd2});
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back('{pc: 4'd1,  fv: 1'b1, cnt: 2'd3});
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back('{pc: 4'd2,  fv: 1'b1, cnt: 2'd3});
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back('{pc: 4'd3,  fv: 1'b1, cnt: 2'd3});
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_s.push_back(e[i]);
      tick();
      exp_o = sb_s.pop_front();
      got   = '{pc: pc_s, fv: fetch_valid_s, cnt: instr_count_s};
      vectors++;
      if (got !== exp_o) begin
        miscompares++;
        $display("FAIL wrap[%0d] got pc=%0d fv=%0b cnt=%0d want pc=%0d fv=%0b cnt=%0d",
                 i, got.pc, got.fv, got.cnt, exp_o.pc, exp_o.fv, exp_o.cnt);
      end
    end
  endtask

  // Reset while in BRANCH; later halt and restart from HALT.
  task automatic test_reset_in_branch();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, exp_o;
    s.push_back(st(0, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back(ob(0, 1, 0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(1, 1, 0, 0, 0, 1));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(2, 1, 0, 0, 0, 2));
    s.push_back(st(1, 0, 0, 0, 1, 8'd1)); e.push_back(ob(2, 0, 1, 1, 0, 3));
    s.push_back(st(0, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(0, 0, 0, 0, 0, 0));
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back(ob(0, 1, 0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(1, 1, 0, 0, 0, 1));
    s.push_back(st(1, 0, 0, 0, 0, 8'd0)); e.push_back(ob(2, 1, 0, 0, 0, 2));
    s.push_back(st(1, 0, 0, 1, 0, 8'd0)); e.push_back(ob(2, 0, 0, 0, 1, 2));
    s.push_back(st(1, 1, 0, 0, 0, 8'd0)); e.push_back(ob(0, 1, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb.push_back(e[i]);
      tick();
      exp_o = sb.pop_front();
      got   = cur_obs();
      vectors++;
      if (got !== exp_o) begin
        miscompares++;
        $display("FAIL rstbr[%0d] got %s want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    Reset_n      = 1'b0;
    start        = 1'b0;
    stall        = 1'b0;
    halt_req     = 1'b0;
    branch_taken = 1'b0;
    branch_sel   = 8'd0;

    test_reset();
    test_run();
    test_branch();
    test_halt_priority();
    test_stall();
    test_wrap_saturate();
    test_reset_in_branch();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
